// File: rtl/dma_io_peripheral_if.sv
// DMA bus side (DREQ/DACK/strobes/DB) plus local push/pop streams of the DMA I/O peripheral.
// The peripheral uses the slave modport; the controller or bench acts as master.
interface dma_io_peripheral_if #(
    parameter int DATA_W = 8
) ();
    logic              DACK;
    logic              IOR_N;
    logic              IOW_N;
    logic              EOP_N;
    logic [DATA_W-1:0] DB_in;
    logic [DATA_W-1:0] DB_out;
    logic              DB_oe;
    logic              DREQ;
    logic              push_valid;
    logic              push_ready;
    logic [DATA_W-1:0] push_data;
    logic              pop_valid;
    logic              pop_ready;
    logic [DATA_W-1:0] pop_data;

    modport slave (
        input  DACK, IOR_N, IOW_N, EOP_N, DB_in, push_valid, push_data, pop_ready,
        output DB_out, DB_oe, DREQ, push_ready, pop_valid, pop_data
    );

    modport master (
        output DACK, IOR_N, IOW_N, EOP_N, DB_in, push_valid, push_data, pop_ready,
        input  DB_out, DB_oe, DREQ, push_ready, pop_valid, pop_data
    );
endinterface

// File: rtl/dma_io_peripheral.sv
// Single-channel device-side DMA endpoint for an 8237-style controller, with a local FIFO
// that sources bytes on IOR_N strobes (dir=0) or sinks bytes from IOW_N strobes (dir=1).
module dma_io_peripheral #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               start,
    input  logic               dir,
    input  logic               demand,
    input  logic [COUNT_W-1:0] xfer_len,
    dma_io_peripheral_if.slave bus,
    output logic               busy,
    output logic               done,
    output logic               tc_hit
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARMED = 3'd1;
    localparam logic [2:0] REQ   = 3'd2;
    localparam logic [2:0] ACK   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]         state, state_next;
    logic               dir_q, demand_q;
    logic [COUNT_W-1:0] remaining;
    logic               dreq_q;
    logic [DATA_W-1:0]  db_out_q, wr_byte;
    logic               ior_prev, iow_prev;
    logic               tc_set;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      wptr, rptr, rptr_next;
    logic [AW:0]        count, count_next;
    logic [DATA_W-1:0]  wdata, head_next;

    logic idle, in_ack, full, empty;
    logic local_push, local_pop, rd_strobe, wr_strobe, strobe;
    logic do_push, do_pop, eop, req_now, req_next;

    assign idle   = (state == IDLE);
    assign in_ack = (state == ACK);
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);

    assign bus.push_ready = !full && (idle || !dir_q);
    assign bus.pop_valid  = !empty && (idle || dir_q);
    assign bus.pop_data   = mem[rptr];
    assign local_push     = bus.push_valid && bus.push_ready;
    assign local_pop      = bus.pop_valid && bus.pop_ready;

    // A strobe completes on the cycle the strobe line is seen high again after being low.
    assign rd_strobe = in_ack && !dir_q && bus.DACK && !ior_prev && bus.IOR_N;
    assign wr_strobe = in_ack &&  dir_q && bus.DACK && !iow_prev && bus.IOW_N;
    assign strobe    = rd_strobe || wr_strobe;
    assign eop       = !bus.EOP_N && bus.DACK;

    assign do_push = local_push || wr_strobe;
    assign do_pop  = local_pop  || rd_strobe;
    assign wdata   = wr_strobe ? wr_byte : bus.push_data;

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    assign rptr_next = do_pop ? rptr + AW'(1) : rptr;
    // Bypass the write when the byte being pushed becomes the new head.
    assign head_next = (do_push && (rptr_next == wptr)) ? wdata : mem[rptr_next];

    assign req_now  = dir_q ? !full : !empty;
    assign req_next = dir_q ? (count_next != FULL_CNT) : (count_next != '0);

    always_comb begin
        state_next = state;
        tc_set     = 1'b0;
        case (state)
            IDLE:  if (start) state_next = ARMED;
            ARMED: if (req_now) state_next = REQ;
            REQ: begin
                if (eop)           state_next = DONE;
                else if (bus.DACK) state_next = ACK;
            end
            ACK: begin
                if (strobe) begin
                    if (remaining == '0) begin
                        state_next = DONE;
                        tc_set     = 1'b1;
                    end else if (eop) begin
                        state_next = DONE;
                    end else if (demand_q && req_next) begin
                        state_next = ACK;
                    end else begin
                        state_next = ARMED;
                    end
                end else if (eop) begin
                    state_next = DONE;
                end else if (!bus.DACK) begin
                    state_next = REQ;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= IDLE;
            dir_q     <= 1'b0;
            demand_q  <= 1'b0;
            remaining <= '0;
            tc_hit    <= 1'b0;
            dreq_q    <= 1'b0;
            db_out_q  <= '0;
            wr_byte   <= '0;
            ior_prev  <= 1'b1;
            iow_prev  <= 1'b1;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
        end else begin
            state    <= state_next;
            dreq_q   <= (state_next == REQ) || (state_next == ACK);
            ior_prev <= bus.IOR_N;
            iow_prev <= bus.IOW_N;
            if (idle && start) begin
                dir_q     <= dir;
                demand_q  <= demand;
                remaining <= xfer_len;
                tc_hit    <= 1'b0;
            end else if (strobe && (remaining != '0)) begin
                remaining <= remaining - COUNT_W'(1);
            end
            if (tc_set) tc_hit <= 1'b1;
            if (in_ack && dir_q && bus.DACK && !bus.IOW_N) wr_byte <= bus.DB_in;
            // The head only changes on a pop, so DB_out holds for the whole strobe.
            if (!idle && !dir_q && (count_next != '0)) db_out_q <= head_next;
            if (do_push) wptr <= wptr + AW'(1);
            rptr  <= rptr_next;
            count <= count_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr] <= wdata;
    end

    assign bus.DREQ   = dreq_q;
    assign bus.DB_out = db_out_q;
    assign bus.DB_oe  = in_ack && !dir_q && bus.DACK && !bus.IOR_N;
    assign busy       = !idle;
    assign done       = (state == DONE);
endmodule
